clk_gate_ctrl: RTL and testbench

- Multi-channel clock-gating controller for the low-power system.
- Each channel owns one gated clock domain (e.g. ALU, register file, UART slices) and holds its clock off until a functional requester asks for it.
- Runs a wake-up delay before acknowledging the requester, then automatically gates the clock off after a programmable idle hold-off.
- Each gated clock is produced by a library ICG latch cell driven from a registered enable OR'd with the DFT test enable.

---
 rtl/clk_gate_ctrl_if.sv | 32 +++
 rtl/clk_gate_ctrl.sv | 132 +++++++++++++
 tb/tb_clk_gate_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_if.sv
// Handshake bundle between clock requesters and the clock-gating controller.
// The master side requests clocks and programs the idle hold-off.
// The slave side (the controller) reports channel state back.
interface clk_gate_ctrl_if #(
   parameter int NUM_CH = 4,
   parameter int IDLE_W = 4
);
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] force_on;
   logic [IDLE_W-1:0] idle_thresh;
   logic [NUM_CH-1:0] ack;
   logic [NUM_CH-1:0] gate_en;
   logic              any_on;

   modport master (
      output req,
      output force_on,
      output idle_thresh,
      input  ack,
      input  gate_en,
      input  any_on
   );

   modport slave (
      input  req,
      input  force_on,
      input  idle_thresh,
      output ack,
      output gate_en,
      output any_on
   );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller.
// Each channel wakes its clock on request, waits WAKE_CYCLES before acking,
// and gates the clock off again after idle_thresh+1 consecutive idle cycles.
// The gated clock comes from a latch-based ICG (TLATNCAX3M behaviour):
// the enable is captured while CLK is low, so GCLK never glitches.
module clk_gate_ctrl #(
   parameter int NUM_CH      = 4,
   parameter int IDLE_W      = 4,
   parameter int WAKE_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              test_en,
   clk_gate_ctrl_if.slave    bus,
   output logic [NUM_CH-1:0] GCLK
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2
   } state_t;

   localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

   logic [NUM_CH-1:0] act;
   logic [NUM_CH-1:0] live_vec;
   logic [NUM_CH-1:0] gate_en_vec;
   logic [NUM_CH-1:0] ack_vec;
   logic              any_on_reg;

   // force_on behaves exactly like a held request
   assign act = bus.req | bus.force_on;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t            state_reg;
      logic [3:0]        wake_cnt_reg;
      logic [IDLE_W-1:0] idle_cnt_reg;
      logic              gate_en_reg;
      logic              ack_reg;
      logic              live_next;
      logic              en_lat;

      // Whether the channel's clock is enabled after the coming edge
      always_comb begin
         live_next = 1'b0;
         if (RST) begin
            case (state_reg)
               ST_OFF:  live_next = act[gi];
               ST_WAKE: live_next = 1'b1;
               ST_ON:   live_next = act[gi] || (idle_cnt_reg != bus.idle_thresh);
               default: live_next = 1'b0;
            endcase
         end
      end

      // Per-channel OFF -> WAKE -> ON -> OFF sequencer with registered outputs
      always_ff @(posedge CLK) begin
         if (!RST) begin
            state_reg    <= ST_OFF;
            wake_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            gate_en_reg  <= 1'b0;
            ack_reg      <= 1'b0;
         end else begin
            gate_en_reg <= live_next;
            case (state_reg)
               ST_OFF: begin
                  ack_reg      <= 1'b0;
                  wake_cnt_reg <= '0;
                  idle_cnt_reg <= '0;
                  if (act[gi]) begin
                     state_reg <= ST_WAKE;
                  end
               end
               ST_WAKE: begin
                  // request is deliberately ignored: the wake always completes
                  idle_cnt_reg <= '0;
                  if (wake_cnt_reg == WAKE_LAST) begin
                     state_reg <= ST_ON;
                     ack_reg   <= 1'b1;
                  end else begin
                     wake_cnt_reg <= wake_cnt_reg + 4'd1;
                  end
               end
               ST_ON: begin
                  // a request on the timeout edge wins and restarts the hold-off
                  if (act[gi]) begin
                     idle_cnt_reg <= '0;
                  end else if (idle_cnt_reg == bus.idle_thresh) begin
                     state_reg    <= ST_OFF;
                     ack_reg      <= 1'b0;
                     idle_cnt_reg <= '0;
                  end else begin
                     idle_cnt_reg <= idle_cnt_reg + 1'b1;
                  end
               end
               default: begin
                  state_reg <= ST_OFF;
                  ack_reg   <= 1'b0;
               end
            endcase
         end
      end

      // ICG latch: transparent while CLK is low, holds during the high phase
      always_latch begin
         if (!CLK) begin
            en_lat <= gate_en_reg | test_en;
         end
      end

      assign GCLK[gi]        = CLK & en_lat;
      assign live_vec[gi]    = live_next;
      assign gate_en_vec[gi] = gate_en_reg;
      assign ack_vec[gi]     = ack_reg;
   end

   // Summary flag registered on the same edge as the individual enables
   always_ff @(posedge CLK) begin
      if (!RST) begin
         any_on_reg <= 1'b0;
      end else begin
         any_on_reg <= |live_vec;
      end
   end

   assign bus.gate_en = gate_en_vec;
   assign bus.ack     = ack_vec;
   assign bus.any_on  = any_on_reg;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed testbench for clk_gate_ctrl (NUM_CH=4, IDLE_W=4, WAKE_CYCLES=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_clk_gate_ctrl;

   localparam int NUM_CH = 4;
   localparam int IDLE_W = 4;

   logic              CLK;
   logic              RST;
   logic              test_en;
   logic [NUM_CH-1:0] GCLK;

   int n_checks = 0;
   int n_errors = 0;
   int gclk_cnt;

   clk_gate_ctrl_if #(.NUM_CH(NUM_CH), .IDLE_W(IDLE_W)) bus ();

   clk_gate_ctrl #(
      .NUM_CH      (NUM_CH),
      .IDLE_W      (IDLE_W),
      .WAKE_CYCLES (2)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .test_en (test_en),
      .bus     (bus.slave),
      .GCLK    (GCLK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset with all requests high ----
      RST             = 1'b0;
      test_en         = 1'b0;
      bus.req         = 4'hF;
      bus.force_on    = 4'h0;
      bus.idle_thresh = 4'd3;
      tick();
      tick();
      check("rst_ack",     bus.ack,     4'h0);
      check("rst_gate_en", bus.gate_en, 4'h0);
      check("rst_any_on",  bus.any_on,  1'b0);
      check("rst_gclk",    GCLK,        4'h0);

      // ---- release with req[0] held: gate_en after edge 1, ack after edge 3 ----
      bus.req = 4'b0001;
      RST     = 1'b1;
      tick();
      check("wk0_gate_e1", bus.gate_en, 4'b0001);
      check("wk0_ack_e1",  bus.ack,     4'b0000);
      check("wk0_any_e1",  bus.any_on,  1'b1);
      tick();
      check("wk0_ack_e2",  bus.ack,     4'b0000);
      check("wk0_gclk_e2", GCLK,        4'b0001);
      tick();
      check("wk0_ack_e3",  bus.ack,     4'b0001);
      bus.req = 4'b0000;
      tick(); tick(); tick();
      check("to0_gate_3",  bus.gate_en, 4'b0001);
      tick();
      check("to0_gate_4",  bus.gate_en, 4'b0000);
      check("to0_ack_4",   bus.ack,     4'b0000);

      // ---- idle timeout on ch1, single-cycle request, thresh=3 ----
      bus.idle_thresh = 4'd3;
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b0000;
      tick();
      tick();
      check("to1_ack_on",  bus.ack,     4'b0010);
      gclk_cnt = 0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         gclk_cnt += int'(GCLK[1]);
         if (k == 3) check("to1_ack_3",  bus.ack,     4'b0010);
         if (k == 4) begin
            check("to1_gate_4", bus.gate_en, 4'b0000);
            check("to1_ack_4",  bus.ack,     4'b0000);
         end
      end
      check("to1_gclk_cnt", gclk_cnt, 4);

      // ---- re-request on the exact timeout edge, thresh=2 ----
      bus.idle_thresh = 4'd2;
      bus.req = 4'b0100;
      tick();
      bus.req = 4'b0000;
      tick();
      tick();
      check("bd2_ack_on",  bus.ack,     4'b0100);
      tick();
      tick();
      bus.req = 4'b0100;
      tick();
      check("bd2_gate_hit", bus.gate_en, 4'b0100);
      bus.req = 4'b0000;
      tick();
      check("bd2_gclk",    GCLK[2],     1'b1);
      tick();
      check("bd2_gate_2",  bus.gate_en, 4'b0100);
      tick();
      check("bd2_gate_off", bus.gate_en, 4'b0000);

      // ---- force_on keeps ch3 ON indefinitely ----
      bus.idle_thresh = 4'd0;
      bus.force_on    = 4'b1000;
      tick(); tick(); tick();
      check("fo3_ack_on",  bus.ack,     4'b1000);
      for (int k = 0; k < 10; k++) tick();
      check("fo3_ack_hold", bus.ack,     4'b1000);
      check("fo3_gate_hold", bus.gate_en, 4'b1000);
      bus.force_on = 4'b0000;
      tick();
      check("fo3_gate_off", bus.gate_en, 4'b0000);
      check("fo3_any_off", bus.any_on,  1'b0);

      // ---- test_en with all channels OFF ----
      test_en = 1'b1;
      tick();
      tick();
      check("te_gclk_hi",  GCLK,        4'hF);
      check("te_gate_en",  bus.gate_en, 4'h0);
      check("te_ack",      bus.ack,     4'h0);
      #5;
      check("te_gclk_lo",  GCLK,        4'h0);
      test_en = 1'b0;

      // ---- reset one cycle into WAKE, then full restart ----
      bus.idle_thresh = 4'd3;
      bus.req = 4'b0001;
      tick();
      check("rw_gate_e1",  bus.gate_en, 4'b0001);
      RST = 1'b0;
      tick();
      check("rw_gate_rst", bus.gate_en, 4'b0000);
      check("rw_ack_rst",  bus.ack,     4'b0000);
      RST = 1'b1;
      tick();
      check("rw_gate_r1",  bus.gate_en, 4'b0001);
      check("rw_ack_r1",   bus.ack,     4'b0000);
      tick();
      check("rw_ack_r2",   bus.ack,     4'b0000);
      tick();
      check("rw_ack_r3",   bus.ack,     4'b0001);
      bus.req = 4'b0000;
      tick(); tick(); tick(); tick();
      check("rw_gate_off", bus.gate_en, 4'b0000);

      // ---- all channels together, thresh=0 ----
      bus.idle_thresh = 4'd0;
      bus.req = 4'hF;
      tick();
      check("par_gate_e1", bus.gate_en, 4'hF);
      check("par_ack_e1",  bus.ack,     4'h0);
      tick();
      check("par_ack_e2",  bus.ack,     4'h0);
      tick();
      check("par_ack_e3",  bus.ack,     4'hF);
      bus.req = 4'h0;
      tick();
      check("par_gate_off", bus.gate_en, 4'h0);
      check("par_ack_off", bus.ack,     4'h0);
      check("par_any_off", bus.any_on,  1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
